inst_loader: RTL and testbench

Boot-time program loader that writes the instruction ROM/RAM the pipelined core fetches from. It receives a framed byte stream over a valid/ready handshake and assembles 26-bit instruction words little-endian. It writes them to consecutive instruction-memory addresses starting at 0 and holds the core in reset until a complete frame passes its checksum. It sits between the host byte link and the instruction-memory write port, alongside the core's `pc`/fetch path.

---
 rtl/inst_loader_pkg.sv | 24 ++
 rtl/inst_loader_if.sv | 29 ++
 rtl/inst_loader_word_asm.sv | 41 ++++
 rtl/inst_loader.sv | 178 +++++++++++++++++
 tb/tb_inst_loader.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/inst_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared types and constants for the boot-time program loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    // Loader frame-parsing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_LO = 3'd1,
        CNT_HI = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } ldr_state_t;

    localparam logic [7:0] LDR_HEADER         = 8'hA5;
    localparam int         LDR_BYTES_PER_WORD = 4;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/inst_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_loader_if
//  Description : Host byte link plus instruction-memory write port of the
//                loader. The master side is the loader itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_loader_if #(
    parameter int ADDR_W = 16,
    parameter int INST_W = 26
) ();
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_data;

    modport master (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_data
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_data
    );
endinterface : inst_loader_if
`default_nettype wire

// File: rtl/inst_loader_word_asm.sv
`default_nettype none
// ============================================================================
//  Module      : loader_word_asm
//  Description : Assembles accepted bytes into 32-bit little-endian words and
//                pulses word_valid_o on the byte that completes a word.
//  Revision    : 1.0 - initial release
// ============================================================================
module loader_word_asm
    import loader_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        accept_i,
    input  wire logic        clear_i,
    input  wire logic [7:0]  byte_i,
    output logic             word_valid_o,
    output logic [31:0]      word_o
);

    localparam logic [1:0] c_last_idx = 2'(LDR_BYTES_PER_WORD - 1);

    logic [1:0]  idx_q;
    logic [31:0] shift_q;

    // First byte lands in the LSBs once the fourth byte has been shifted in
    assign word_o       = {byte_i, shift_q[31:8]};
    assign word_valid_o = accept_i && (idx_q == c_last_idx);

    // Byte index and shift register; cleared whenever no word is in progress
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            idx_q   <= 2'd0;
            shift_q <= 32'd0;
        end else if (accept_i) begin
            idx_q   <= idx_q + 2'd1;
            shift_q <= word_o;
        end
    end

endmodule : loader_word_asm
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
//  Module      : inst_loader
//  Description : Boot-time program loader. Parses a framed byte stream,
//                writes 26-bit instructions from address 0 and releases the
//                core from reset only after a frame passes its checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_loader
    import loader_pkg::*;
#(
    parameter int INST_W = 26,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 65536
) (
    input  wire logic      clk,
    input  wire logic      rst,
    inst_loader_if.master  bus,
    output logic           core_rst,
    output logic           done,
    output logic           error
);

    localparam logic [16:0] c_max_words = 17'(DEPTH);

    ldr_state_t        state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [16:0]       wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        csum_q, csum_d;
    logic              bad_q, bad_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [INST_W-1:0] mem_data_q, mem_data_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              w_accept;
    logic              w_is_hdr;
    logic [15:0]       w_new_count;
    logic              w_word_valid;
    logic [31:0]       w_word;

    // One bubble after every write keeps the memory port to one word per 5 cycles
    assign bus.in_ready = !mem_we_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign core_rst     = core_rst_q;
    assign done         = done_q;
    assign error        = error_q;

    assign w_accept    = bus.in_valid && bus.in_ready;
    assign w_is_hdr    = (bus.in_data == LDR_HEADER);
    assign w_new_count = {bus.in_data, count_q[7:0]};

    loader_word_asm u_word_asm (
        .clk          (clk),
        .rst          (rst),
        .accept_i     (w_accept && (state_q == DATA)),
        .clear_i      (state_q != DATA),
        .byte_i       (bus.in_data),
        .word_valid_o (w_word_valid),
        .word_o       (w_word)
    );

    // Frame parser: next-state, counters, checksum and status flags
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wcnt_d     = wcnt_q;
        waddr_d    = waddr_q;
        csum_d     = csum_q;
        bad_d      = bad_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        core_rst_d = core_rst_q;
        done_d     = done_q;
        error_d    = error_q;
        if (w_accept) begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (w_is_hdr) begin
                        state_d    = CNT_LO;
                        csum_d     = 8'd0;
                        bad_d      = 1'b0;
                        wcnt_d     = 17'd0;
                        waddr_d    = '0;
                        core_rst_d = 1'b1;
                        done_d     = 1'b0;
                        error_d    = 1'b0;
                    end
                end
                CNT_LO: begin
                    count_d[7:0] = bus.in_data;
                    csum_d       = csum_q ^ bus.in_data;
                    state_d      = CNT_HI;
                end
                CNT_HI: begin
                    count_d = w_new_count;
                    csum_d  = csum_q ^ bus.in_data;
                    if ({1'b0, w_new_count} > c_max_words) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end else if (w_new_count == 16'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    csum_d = csum_q ^ bus.in_data;
                    if (w_word_valid) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = waddr_q;
                        mem_data_d = w_word[INST_W-1:0];
                        waddr_d    = waddr_q + 1'b1;
                        wcnt_d     = wcnt_q + 17'd1;
                        // Oversized words are still written, truncated, but fail the frame
                        if (w_word[31:INST_W] != '0) begin
                            bad_d = 1'b1;
                        end
                        if ((wcnt_q + 17'd1) == {1'b0, count_q}) begin
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if ((bus.in_data == csum_q) && !bad_q) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        core_rst_d = 1'b0;
                    end else begin
                        state_d    = ERR;
                        error_d    = 1'b1;
                        core_rst_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= 16'd0;
            wcnt_q     <= 17'd0;
            waddr_q    <= '0;
            csum_q     <= 8'd0;
            bad_q      <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wcnt_q     <= wcnt_d;
            waddr_q    <= waddr_d;
            csum_q     <= csum_d;
            bad_q      <= bad_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

endmodule : inst_loader
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_loader
//  Description : Scoreboard bench for inst_loader. DUT a uses full depth,
//                DUT b uses DEPTH=4 for the oversize-count case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_loader;

    typedef struct packed {
        logic [15:0] a;
        logic [25:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic core_rst_a, done_a, error_a;
    logic core_rst_b, done_b, error_b;

    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];
    logic [7:0] stim[$];
    logic prev_we_a = 1'b0;

    inst_loader_if #(.ADDR_W(16), .INST_W(26)) ifa ();
    inst_loader_if #(.ADDR_W(16), .INST_W(26)) ifb ();

    inst_loader #(.INST_W(26), .ADDR_W(16), .DEPTH(65536)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .bus      (ifa.master),
        .core_rst (core_rst_a),
        .done     (done_a),
        .error    (error_a)
    );

    inst_loader #(.INST_W(26), .ADDR_W(16), .DEPTH(4)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .bus      (ifb.master),
        .core_rst (core_rst_b),
        .done     (done_b),
        .error    (error_b)
    );

    always #5 clk = ~clk;

    // Monitor: every write on DUT a must match the next expected write
    always @(negedge clk) begin
        if (ifa.mem_we === 1'b1) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_a: unexpected write addr=%0h data=%0h", ifa.mem_addr, ifa.mem_data);
            end else begin
                e = exp_q.pop_front();
                if (ifa.mem_addr !== e.a || ifa.mem_data !== e.d) begin
                    errors++;
                    $display("FAIL write_a: got addr=%0h data=%0h expected addr=%0h data=%0h",
                             ifa.mem_addr, ifa.mem_data, e.a, e.d);
                end
            end
            checks++;
            if (ifa.in_ready !== 1'b0 || prev_we_a) begin
                errors++;
                $display("FAIL bubble_a: in_ready=%0b prev_we=%0b expected in_ready=0 single-cycle strobe",
                         ifa.in_ready, prev_we_a);
            end
        end
        prev_we_a = (ifa.mem_we === 1'b1);
        if (ifb.mem_we === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL write_b: unexpected write addr=%0h data=%0h expected none", ifb.mem_addr, ifb.mem_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] b);
        int tries;
        @(negedge clk);
        if (sel) begin ifb.in_data = b; ifb.in_valid = 1'b1; end
        else     begin ifa.in_data = b; ifa.in_valid = 1'b1; end
        tries = 0;
        while (((sel ? ifb.in_ready : ifa.in_ready) !== 1'b1) && tries < 16) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 16) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck low for byte %0h expected 1", b);
        end
        @(posedge clk);
        #1;
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
    endtask

    task automatic send_stim(input bit sel);
        foreach (stim[i]) send(sel, stim[i]);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_core_rst"}, 32'(core_rst_a), 32'd1);
        chk({tag, "_done"},     32'(done_a),     32'd0);
        chk({tag, "_error"},    32'(error_a),    32'd0);
        chk({tag, "_mem_we"},   32'(ifa.mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(ifa.mem_addr), 32'd0);
        chk({tag, "_mem_data"}, 32'(ifa.mem_data), 32'd0);
        chk({tag, "_in_ready"}, 32'(ifa.in_ready), 32'd1);
    endtask

    task automatic good_frame();
        exp_q.push_back('{16'd0, 26'h0123456});
        exp_q.push_back('{16'd1, 26'h3FFFFFF});
        stim = '{8'hA5, 8'h02, 8'h00, 8'h56, 8'h34, 8'h12, 8'h00,
                 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h8E};
        send_stim(1'b0);
        @(negedge clk);
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ifa.in_data = 8'h00; ifa.in_valid = 1'b0;
        ifb.in_data = 8'h00; ifb.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        chk("reset_b_core_rst", 32'(core_rst_b), 32'd1);
        rst = 1'b0;

        // Good frame preceded by garbage
        exp_q.push_back('{16'd0, 26'h0123456});
        exp_q.push_back('{16'd1, 26'h3FFFFFF});
        stim = '{8'h11, 8'h22, 8'hA5, 8'h02, 8'h00, 8'h56, 8'h34, 8'h12, 8'h00,
                 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h8E};
        send_stim(1'b0);
        @(negedge clk);
        chk("good_done", 32'(done_a), 32'd1);
        chk("good_core_rst", 32'(core_rst_a), 32'd0);
        chk("good_error", 32'(error_a), 32'd0);
        chk("good_writes_left", 32'(exp_q.size()), 32'd0);

        // Bad checksum (reload from DONE)
        exp_q.push_back('{16'd0, 26'h0123456});
        exp_q.push_back('{16'd1, 26'h3FFFFFF});
        stim = '{8'hA5, 8'h02, 8'h00, 8'h56, 8'h34, 8'h12, 8'h00,
                 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h8F};
        send_stim(1'b0);
        @(negedge clk);
        chk("badsum_error", 32'(error_a), 32'd1);
        chk("badsum_done", 32'(done_a), 32'd0);
        chk("badsum_core_rst", 32'(core_rst_a), 32'd1);
        chk("badsum_writes_left", 32'(exp_q.size()), 32'd0);

        // Empty frame
        stim = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_stim(1'b0);
        @(negedge clk);
        chk("empty_done", 32'(done_a), 32'd1);
        chk("empty_core_rst", 32'(core_rst_a), 32'd0);
        chk("empty_error", 32'(error_a), 32'd0);

        // Out-of-range word with correct checksum
        exp_q.push_back('{16'd0, 26'h0000000});
        stim = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h05};
        send_stim(1'b0);
        @(negedge clk);
        chk("oor_error", 32'(error_a), 32'd1);
        chk("oor_done", 32'(done_a), 32'd0);
        chk("oor_writes_left", 32'(exp_q.size()), 32'd0);

        // Oversize count on the DEPTH=4 instance
        stim = '{8'hA5, 8'h05, 8'h00};
        send_stim(1'b1);
        chk("oversize_error", 32'(error_b), 32'd1);
        chk("oversize_core_rst", 32'(core_rst_b), 32'd1);
        stim = '{8'h01, 8'h02, 8'h00, 8'h03, 8'h00};
        send_stim(1'b1);
        @(negedge clk);
        chk("oversize_hold_error", 32'(error_b), 32'd1);
        chk("oversize_hold_done", 32'(done_b), 32'd0);

        // Reload after DONE
        good_frame();
        chk("pre_reload_done", 32'(done_a), 32'd1);
        send(1'b0, 8'hA5);
        @(negedge clk);
        chk("reload_core_rst", 32'(core_rst_a), 32'd1);
        chk("reload_done", 32'(done_a), 32'd0);
        exp_q.push_back('{16'd0, 26'h0ABCDEF});
        stim = '{8'h01, 8'h00, 8'hEF, 8'hCD, 8'hAB, 8'h00, 8'h88};
        send_stim(1'b0);
        @(negedge clk);
        chk("reload_frame_done", 32'(done_a), 32'd1);
        chk("reload_frame_core_rst", 32'(core_rst_a), 32'd0);
        chk("reload_writes_left", 32'(exp_q.size()), 32'd0);

        // Reset mid-DATA, then a full good frame
        stim = '{8'hA5, 8'h02, 8'h00, 8'h56, 8'h34};
        send_stim(1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        rst = 1'b0;
        good_frame();
        chk("post_rst_done", 32'(done_a), 32'd1);
        chk("post_rst_core_rst", 32'(core_rst_a), 32'd0);
        chk("post_rst_writes_left", 32'(exp_q.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_inst_loader
`default_nettype wire
